// File: rtl/analog_gpio_wb_ctrl.sv
// Wishbone GPIO controller: output/enable registers, synchronised inputs, sticky edge capture, IRQ.
// Optional logic-analyzer override and readback when ANALOG_GPIO_LA_EN is defined.
module analog_gpio_wb_ctrl #(
   parameter int unsigned NGPIO       = 27,
   parameter logic [31:0] BASE_ADR    = 32'h3000_0000,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             wbs_stb_i,
   input  logic             wbs_cyc_i,
   input  logic             wbs_we_i,
   input  logic [3:0]       wbs_sel_i,
   input  logic [31:0]      wbs_adr_i,
   input  logic [31:0]      wbs_dat_i,
   output logic             wbs_ack_o,
   output logic [31:0]      wbs_dat_o,
   input  logic [NGPIO-1:0] io_in,
   output logic [NGPIO-1:0] io_out,
   output logic [NGPIO-1:0] io_oeb,
   output logic             irq_o,
   input  logic [127:0]     la_data_in,
   input  logic [127:0]     la_oen,
   output logic [127:0]     la_data_out
);

   localparam int unsigned PrimeW = $clog2(SYNC_STAGES + 2);
   localparam logic [PrimeW-1:0] PrimeDone = PrimeW'(SYNC_STAGES + 1);

   localparam logic [5:0] AdrOut    = 6'h00;
   localparam logic [5:0] AdrOeb    = 6'h01;
   localparam logic [5:0] AdrIn     = 6'h02;
   localparam logic [5:0] AdrEdge   = 6'h03;
   localparam logic [5:0] AdrRiseEn = 6'h04;
   localparam logic [5:0] AdrFallEn = 6'h05;
   localparam logic [5:0] AdrMask   = 6'h06;
   localparam logic [5:0] AdrId     = 6'h07;

   logic [SYNC_STAGES-1:0][NGPIO-1:0] sync_q, sync_d;
   logic [NGPIO-1:0] prev_q, prev_d;
   logic [NGPIO-1:0] out_q, out_d;
   logic [NGPIO-1:0] oeb_q, oeb_d;
   logic [NGPIO-1:0] edge_q, edge_d;
   logic [NGPIO-1:0] rise_en_q, rise_en_d;
   logic [NGPIO-1:0] fall_en_q, fall_en_d;
   logic [NGPIO-1:0] irq_mask_q, irq_mask_d;
   logic [PrimeW-1:0] prime_q, prime_d;
   logic             irq_q, irq_d;
   logic             ack_q, ack_d;
   logic [31:0]      dat_q, dat_d;

   logic             hit, accept, wr, det_en;
   logic [5:0]       reg_idx;
   logic [31:0]      wmask, rdata;
   logic [NGPIO-1:0] wm, wd, in_sync, edge_set, edge_clr;

   function automatic logic [NGPIO-1:0] merge(input logic [NGPIO-1:0] old,
                                              input logic [NGPIO-1:0] d,
                                              input logic [NGPIO-1:0] m);
      return (old & ~m) | (d & m);
   endfunction

   always_comb begin
      hit     = (wbs_adr_i[31:8] == BASE_ADR[31:8]);
      accept  = wbs_stb_i & wbs_cyc_i & ~ack_q & hit;
      wr      = accept & wbs_we_i;
      reg_idx = wbs_adr_i[7:2];
      wmask   = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
      wm      = wmask[NGPIO-1:0];
      wd      = wbs_dat_i[NGPIO-1:0];
      in_sync = sync_q[SYNC_STAGES-1];

      sync_d  = {sync_q[SYNC_STAGES-2:0], io_in};
      prev_d  = in_sync;
      // Hold off edge detection until the synchroniser and prev hold real pad values.
      det_en  = (prime_q == PrimeDone);
      prime_d = det_en ? prime_q : prime_q + PrimeW'(1);

      edge_set = det_en ? ((in_sync & ~prev_q & rise_en_q) | (~in_sync & prev_q & fall_en_q))
                        : '0;
      edge_clr = (wr && reg_idx == AdrEdge) ? (wd & wm) : '0;
      edge_d   = (edge_q & ~edge_clr) | edge_set;
      irq_d    = |(edge_q & irq_mask_q);

      out_d      = out_q;
      oeb_d      = oeb_q;
      rise_en_d  = rise_en_q;
      fall_en_d  = fall_en_q;
      irq_mask_d = irq_mask_q;
      if (wr) begin
         case (reg_idx)
            AdrOut:    out_d      = merge(out_q, wd, wm);
            AdrOeb:    oeb_d      = merge(oeb_q, wd, wm);
            AdrRiseEn: rise_en_d  = merge(rise_en_q, wd, wm);
            AdrFallEn: fall_en_d  = merge(fall_en_q, wd, wm);
            AdrMask:   irq_mask_d = merge(irq_mask_q, wd, wm);
            default: ;
         endcase
      end

      rdata = '0;
      case (reg_idx)
         AdrOut:    rdata[NGPIO-1:0] = out_q;
         AdrOeb:    rdata[NGPIO-1:0] = oeb_q;
         AdrIn:     rdata[NGPIO-1:0] = in_sync;
         AdrEdge:   rdata[NGPIO-1:0] = edge_q;
         AdrRiseEn: rdata[NGPIO-1:0] = rise_en_q;
         AdrFallEn: rdata[NGPIO-1:0] = fall_en_q;
         AdrMask:   rdata[NGPIO-1:0] = irq_mask_q;
         AdrId:     rdata = {16'hA61C, 8'(SYNC_STAGES), 8'(NGPIO)};
         default: ;
      endcase

      ack_d = accept;
      dat_d = accept ? rdata : '0;
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         sync_q     <= '0;
         prev_q     <= '0;
         out_q      <= '0;
         oeb_q      <= '1;
         edge_q     <= '0;
         rise_en_q  <= '0;
         fall_en_q  <= '0;
         irq_mask_q <= '0;
         prime_q    <= '0;
         irq_q      <= 1'b0;
         ack_q      <= 1'b0;
         dat_q      <= '0;
      end else begin
         sync_q     <= sync_d;
         prev_q     <= prev_d;
         out_q      <= out_d;
         oeb_q      <= oeb_d;
         edge_q     <= edge_d;
         rise_en_q  <= rise_en_d;
         fall_en_q  <= fall_en_d;
         irq_mask_q <= irq_mask_d;
         prime_q    <= prime_d;
         irq_q      <= irq_d;
         ack_q      <= ack_d;
         dat_q      <= dat_d;
      end
   end

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_q;
   assign io_oeb    = oeb_q;
   assign irq_o     = irq_q;

   logic unused_bits;
`ifdef ANALOG_GPIO_LA_EN
   // la_oen low hands the pad to the logic analyzer, bit by bit.
   assign io_out      = (out_q & la_oen[NGPIO-1:0]) | (la_data_in[NGPIO-1:0] & ~la_oen[NGPIO-1:0]);
   assign la_data_out = {{(128 - NGPIO){1'b0}}, in_sync};
   assign unused_bits = ^{wbs_adr_i[1:0], la_data_in[127:NGPIO], la_oen[127:NGPIO]};
`else
   assign io_out      = out_q;
   assign la_data_out = '0;
   assign unused_bits = ^{wbs_adr_i[1:0], la_data_in, la_oen};
`endif

endmodule

// File: doc/analog_gpio_wb_ctrl.md
# analog_gpio_wb_ctrl

Wishbone-slave GPIO controller for the user analog project area. It generalises the bare analog wrapper's GPIO bundle into a parametrised, register-mapped block with NGPIO channels. It drives io_out/io_oeb from software registers, synchronises io_in, and captures rising/falling edges into sticky status with a maskable interrupt. It sits inside user_analog_project_wrapper between the management Wishbone port (WB MI A) and the non-analog GPIO pins.

## Interface
- NGPIO, 27, number of GPIO channels (1..32); 27 equals MPRJ_IO_PADS minus ANALOG_PADS.
- BASE_ADR, 32'h3000_0000, block base address; the block decodes wbs_adr_i[31:8] == BASE_ADR[31:8].
- SYNC_STAGES, 2, input synchroniser depth (2..4).

Ports:
- wb_clk_i  in  1  single clock for all logic.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone classic strobe/cycle/write.
- wbs_sel_i  in  4  byte enables.
- wbs_adr_i, wbs_dat_i  in  32 each  address, write data.
- wbs_ack_o  out  1  registered acknowledge.
- wbs_dat_o  out  32  read data, valid with ack.
- io_in  in  NGPIO  pad inputs, asynchronous.
- io_out  out  NGPIO  pad output data.
- io_oeb  out  NGPIO  pad output enable, active-low.
- irq_o  out  1  level interrupt.
- la_data_in, la_oen  in  128 each  logic analyzer; used only with the macro.
- la_data_out  out  128  logic analyzer readback.

## Operation
- Register map (offset = wbs_adr_i[7:2]×4). Bits at and above NGPIO read 0 and ignore writes.
  - 0x00 OUT, RW, reset 0.
  - 0x04 OEB, RW, reset all ones (outputs off).
  - 0x08 IN, RO, synchronised inputs.
  - 0x0C EDGE, W1C, reset 0.
  - 0x10 RISE_EN, RW, reset 0.
  - 0x14 FALL_EN, RW, reset 0.
  - 0x18 IRQ_MASK, RW, reset 0.
  - 0x1C ID, RO, {16'hA61C, 8'(SYNC_STAGES), 8'(NGPIO)}.
- Other offsets inside the 256-byte window: ack, read 0, writes dropped. Addresses outside the window: no ack.
- Writes honour wbs_sel_i per byte. A byte lane with sel=0 is unchanged, including for the W1C register.
- Synchroniser: SYNC_STAGES flops per bit, reset 0. prev holds the last synchronised value.
- Edge detect:
  - rise[i] = sync[i] & ~prev[i] & RISE_EN[i].
  - fall[i] = ~sync[i] & prev[i] & FALL_EN[i].
  - EDGE[i] is set by rise|fall and cleared by writing 1.
  - Set and clear in the same cycle: set wins.
- Prime counter: after reset, edge detection is suppressed for SYNC_STAGES+1 cycles. This prevents a spurious rise when a pad is high at reset release.
- irq_o = registered |(EDGE & IRQ_MASK).
- io_out = OUT. io_oeb = OEB.
- Reset mid-transaction: ack drops immediately, all registers return to reset values, and the master must retry.

## Timing
- Request accepted when stb & cyc & ~ack.
- ack asserts on the next edge for exactly one cycle, even if stb stays high. This gives a minimum of two cycles per access, with no back-to-back acks.
- Write takes effect on the same edge that raises ack. The io_out/io_oeb change is visible in that cycle.
- Read data is sampled from registers at the accept edge and held in wbs_dat_o with ack. wbs_dat_o is 0 when ack is low.
- Pad edge to IN register: SYNC_STAGES cycles.
- Pad edge to EDGE bit: SYNC_STAGES+1 cycles.
- EDGE bit to irq_o: +1 cycle.
- W1C of the last masked bit drops irq_o one cycle after ack.
- Reset values of outputs: wbs_ack_o 0, wbs_dat_o 0, io_out 0, io_oeb all ones, irq_o 0, la_data_out 0.

## Configuration
- ANALOG_GPIO_LA_EN defined:
  - la_data_out[NGPIO-1:0] = synchronised inputs; upper bits are 0.
  - io_out[i] = la_oen[i] ? OUT[i] : la_data_in[i], so LA override is per bit when la_oen is low.
  - OUT readback is still the register value.
- ANALOG_GPIO_LA_EN undefined:
  - la_data_out is tied 0.
  - la_data_in and la_oen are ignored.
  - io_out = OUT.

## Test plan
- Reset with io_in=all ones, RISE_EN written to all ones at the first opportunity → io_oeb=27'h7FFFFFF, io_out=0, EDGE reads 0 (prime suppression).
- Write OUT=32'h0000_00A5 with sel=4'b0001, then sel=4'b0010 with data 32'h0000_3C00 → OUT reads 0x3CA5 and io_out follows on each ack edge.
- RISE_EN[3]=1, IRQ_MASK[3]=1, io_in[3] 0→1 at cycle T → EDGE[3]=1 at T+3, irq_o=1 at T+4. Write EDGE=0x8 → irq_o=0 one cycle after ack.
- Pulse io_in[5] 1→0 on the same cycle a W1C to bit 5 is accepted, with FALL_EN[5]=1 → EDGE[5] remains 1 (set wins).
- Read offsets 0x1C, 0x40 and BASE+0x100 → ID 0xA61C021B, then 0 with ack, then no ack (bench timeout check).
- With ANALOG_GPIO_LA_EN: la_oen[2]=0, la_data_in[2]=1, OUT[2]=0 → io_out[2]=1 and la_data_out[2] mirrors io_in[2] after 2 cycles.
